uart_receive: RTL and testbench

- UART serial-to-parallel receiver. It is the receive-side counterpart of the team's `transmit` block.
- It samples an asynchronous serial line with a clock running at OVERSAMPLE × baud and detects start bits.
- It captures `bitwidth` data bits LSB-first, checks the stop bit, and presents the word with a one-cycle `done` strobe.
- It sits between the RX pin and the host-side logic.

---
 rtl/uart_receive.sv | 170 +++++++++++++++++
 tb/tb_uart_receive.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receive.sv
// UART serial-to-parallel receiver.
// Oversampled start detect, centre sampling, stop check.
module uart_receive #(
  parameter int bitwidth   = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                RXclk,
  input  logic                rstn,
  input  logic                en,
  input  logic                in,
  output logic [bitwidth-1:0] out,
  output logic                done,
  output logic                err,
  output logic                busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(bitwidth + 1);

  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST = IW'(bitwidth - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t state_q, state_d;

  logic                meta_q, meta_d;
  logic                s_q, s_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [bitwidth-1:0] shift_q, shift_d;
  logic [bitwidth-1:0] out_q, out_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  // Next-state: sync chain, bit timing, framing.
  always_comb begin
    meta_d  = in;
    s_d     = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    out_d   = out_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (en && !s_q) begin
          state_d = START;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (!en) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == HALF) begin
          cnt_d = '0;
          if (s_q) begin
            // Low pulse gone by mid-bit: glitch.
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end

      DATA: begin
        if (!en) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == FULL) begin
          cnt_d   = '0;
          // LSB arrives first, so shift in at MSB.
          shift_d = shift_q >> 1;
          shift_d[bitwidth-1] = s_q;
          idx_d   = idx_q + IW'(1);
          if (idx_q == LAST) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (!en) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == FULL) begin
          cnt_d = '0;
          if (s_q) begin
            // Back to IDLE at stop centre: no gap needed.
            out_d   = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK;
          end
        end
      end

      BREAK: begin
        cnt_d = '0;
        if (!en || s_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; sync flops reset high.
  always_ff @(posedge RXclk) begin
    if (!rstn) begin
      state_q <= IDLE;
      meta_q  <= 1'b1;
      s_q     <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive.
// 16 clocks per bit, edge-accurate timing checks.
module tb_uart_receive;

  logic       RXclk;
  logic       rstn;
  logic       en;
  logic       in;
  logic [7:0] out;
  logic       done;
  logic       err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int dcnt  = 0;
  int ecnt  = 0;
  int dcyc  = -1;
  int ecyc  = -1;
  int brise = -1;
  int bfall = -1;
  logic [7:0] dout = '0;
  logic both    = 1'b0;
  logic busy_or = 1'b0;
  logic busy_p  = 1'b0;

  initial RXclk = 1'b0;
  always #5 RXclk = ~RXclk;

  uart_receive #(
    .bitwidth  (8),
    .OVERSAMPLE(16)
  ) dut (
    .RXclk(RXclk),
    .rstn (rstn),
    .en   (en),
    .in   (in),
    .out  (out),
    .done (done),
    .err  (err),
    .busy (busy)
  );

  // One edge; cyc is the number of the edge just passed.
  task automatic tick();
    @(posedge RXclk);
    #1;
    cyc++;
    if (done) begin
      dcnt++;
      dcyc = cyc;
      dout = out;
    end
    if (err) begin
      ecnt++;
      ecyc = cyc;
    end
    if (done && err) both = 1'b1;
    busy_or = busy_or | busy;
    if (busy && !busy_p) brise = cyc;
    if (!busy && busy_p) bfall = cyc;
    busy_p = busy;
  endtask

  task automatic wait_n(input int k);
    repeat (k) tick();
  endtask

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             tag, obs, obs, exp, exp);
    end
  endtask

  // t = first edge that samples the start bit low.
  task automatic send_frame(input logic [7:0] d,
                            input logic stopb,
                            output int t);
    t  = cyc + 1;
    in = 1'b0;
    wait_n(16);
    for (int i = 0; i < 8; i++) begin
      in = d[i];
      wait_n(16);
    end
    in = stopb;
    wait_n(16);
  endtask

  initial begin
    int t;
    int r;
    int d0;
    int e0;
    logic [7:0] d;

    rstn = 1'b0;
    en   = 1'b1;
    in   = 1'b1;
    wait_n(3);
    check("rst_out", int'(out), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    rstn = 1'b1;
    wait_n(5);

    // 0x55 then 0x96 back to back.
    send_frame(8'h55, 1'b1, t);
    check("f55_dcnt", dcnt, 1);
    check("f55_dcyc", dcyc, t + 154);
    check("f55_dout", int'(dout), 'h55);
    check("f55_rise", brise, t + 2);
    check("f55_fall", bfall, t + 154);
    check("f55_ecnt", ecnt, 0);
    send_frame(8'h96, 1'b1, r);
    in = 1'b1;
    wait_n(10);
    check("f96_dcnt", dcnt, 2);
    check("f96_gap", dcyc, t + 314);
    check("f96_dout", int'(dout), 'h96);
    check("f96_out", int'(out), 'h96);
    check("f96_rise", brise, r + 2);

    // Four-cycle low glitch.
    wait_n(10);
    t  = cyc + 1;
    in = 1'b0;
    wait_n(4);
    in = 1'b1;
    wait_n(8);
    check("gl_rise", brise, t + 2);
    check("gl_fall", bfall, t + 10);
    check("gl_busy", int'(busy), 0);
    wait_n(30);
    check("gl_dcnt", dcnt, 2);
    check("gl_ecnt", ecnt, 0);
    check("gl_out", int'(out), 'h96);

    // 0xA3 with low stop, line low 40 more cycles.
    wait_n(20);
    send_frame(8'hA3, 1'b0, t);
    wait_n(40);
    check("fe_ecnt", ecnt, 1);
    check("fe_ecyc", ecyc, t + 154);
    check("fe_dcnt", dcnt, 2);
    check("fe_out", int'(out), 'h96);
    check("fe_brk", int'(busy), 1);
    in = 1'b1;
    wait_n(2);
    check("fe_hold", int'(busy), 1);
    wait_n(1);
    check("fe_idle", int'(busy), 0);
    check("fe_fall", bfall, t + 202);

    // Reset pulse at t+80 during 0x3C.
    wait_n(20);
    d  = 8'h3C;
    d0 = dcnt;
    e0 = ecnt;
    t  = cyc + 1;
    in = 1'b0;
    wait_n(16);
    for (int i = 0; i < 4; i++) begin
      in = d[i];
      wait_n(16);
    end
    rstn = 1'b0;
    in   = d[4];
    wait_n(1);
    check("mr_cyc", cyc, t + 80);
    check("mr_out", int'(out), 0);
    check("mr_busy", int'(busy), 0);
    rstn = 1'b1;
    wait_n(15);
    for (int i = 5; i < 8; i++) begin
      in = d[i];
      wait_n(16);
    end
    in = 1'b1;
    wait_n(16);
    check("mr_nodone", dcnt, d0);
    check("mr_noerr", ecnt, e0);
    check("mr_out2", int'(out), 0);
    // Tail bits 6..7 (low) plus the stop/idle highs
    // form a legal frame after the reset: 0,1,1,...
    wait_n(111);
    check("mr_tail_d", dcnt, d0 + 1);
    check("mr_tail_c", dcyc, t + 266);
    check("mr_tail_v", int'(dout), 'hFE);
    check("mr_tail_e", ecnt, e0);

    // Next good frame 0xC3.
    wait_n(10);
    d0 = dcnt;
    send_frame(8'hC3, 1'b1, t);
    in = 1'b1;
    wait_n(5);
    check("fc3_dcnt", dcnt, d0 + 1);
    check("fc3_dcyc", dcyc, t + 154);
    check("fc3_out", int'(out), 'hC3);

    // en low for one edge in bit 5 of 0xF0.
    wait_n(10);
    d  = 8'hF0;
    d0 = dcnt;
    e0 = ecnt;
    t  = cyc + 1;
    in = 1'b0;
    wait_n(16);
    for (int i = 0; i < 5; i++) begin
      in = d[i];
      wait_n(16);
    end
    in = d[5];
    wait_n(4);
    check("ab_busy1", int'(busy), 1);
    en = 1'b0;
    wait_n(1);
    check("ab_busy0", int'(busy), 0);
    check("ab_fall", bfall, t + 100);
    en = 1'b1;
    wait_n(11);
    for (int i = 6; i < 8; i++) begin
      in = d[i];
      wait_n(16);
    end
    in = 1'b1;
    wait_n(40);
    check("ab_dcnt", dcnt, d0);
    check("ab_ecnt", ecnt, e0);
    check("ab_out", int'(out), 'hC3);

    // en held low for a whole frame.
    en      = 1'b0;
    busy_or = 1'b0;
    send_frame(8'h81, 1'b1, t);
    in = 1'b1;
    wait_n(20);
    check("enl_busy", int'(busy_or), 0);
    check("enl_dcnt", dcnt, d0);
    check("enl_ecnt", ecnt, e0);
    check("enl_out", int'(out), 'hC3);
    en = 1'b1;
    wait_n(5);
    send_frame(8'h81, 1'b1, t);
    in = 1'b1;
    wait_n(5);
    check("en1_dcyc", dcyc, t + 154);
    check("en1_out", int'(out), 'h81);

    // Line low straight out of reset.
    e0   = ecnt;
    d0   = dcnt;
    in   = 1'b0;
    rstn = 1'b0;
    wait_n(1);
    r    = cyc;
    rstn = 1'b1;
    wait_n(159);
    check("low_ecnt", ecnt, e0 + 1);
    check("low_ecyc", ecyc, r + 155);
    check("low_dcnt", dcnt, d0);
    check("low_out", int'(out), 0);
    check("low_brk", int'(busy), 1);
    in = 1'b1;
    wait_n(3);
    check("low_idle", int'(busy), 0);

    check("excl", int'(both), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
